// File: rtl/uart_tx_ser.sv
// uart_tx_ser: UART transmit serializer paced by a synchronized baud square wave.
// Ports: clkin system clock; rst async active-high reset; baud_in baud divider
//   square wave (rising edge = bit boundary); tx_data/tx_valid/tx_ready byte
//   handshake; txd serial line (idle high); busy frame in progress.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit(s).
module uart_tx_ser #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, STOP} state_t;
`endif
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 2);
  // The last stop bit is driven from IDLE so a new start bit can follow it
  // with no gap; STOP only covers any extra stop bits.
  localparam state_t STOP_NEXT = (STOP_BITS > 1) ? STOP : IDLE;
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic txd_q, txd_d, rdy_q, rdy_d, busy_q, busy_d;
  logic tick, acc;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  // sync_q[0..1] synchronize baud_in, sync_q[2] holds the previous synchronized level
  assign tick = sync_q[1] & ~sync_q[2];
  assign acc = tx_valid & rdy_q;
  assign txd = txd_q;
  assign tx_ready = rdy_q;
  assign busy = busy_q;
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      txd_q <= 1'b1;
      rdy_q <= 1'b1;
      busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[1:0], baud_in};
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      txd_q <= txd_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    unique case (state_q)
      IDLE: if (acc) begin
        state_d = ALIGN;
        sh_d = tx_data;
`ifdef UART_TX_PARITY_EN
        par_d = ^tx_data;
`endif
      end
      ALIGN: if (tick) state_d = START;
      START: if (tick) begin
        state_d = DATA;
        cnt_d = '0;
      end
      DATA: if (tick) begin
        if (cnt_q == LAST) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP_NEXT;
`endif
          cnt_d = '0;
        end else begin
          sh_d = sh_q >> 1;
          cnt_d = cnt_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_d = STOP_NEXT;
        cnt_d = '0;
      end
`endif
      STOP: if (tick) begin
        if (cnt_q == SLAST) state_d = IDLE;
        else cnt_d = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
`ifdef UART_TX_PARITY_EN
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] :
            (state_d == PARITY) ? par_q : 1'b1;
`else
    txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
`endif
    rdy_d = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: randomized self-checking bench with a bit-queue frame model.
module tb_uart_tx_ser;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + SB;
`ifdef UART_TX_PARITY_EN
  localparam bit [0:NB-1] E55 = 11'b01010101001;
  localparam bit [0:NB-1] EA3 = 11'b01100010101;
`else
  localparam bit [0:NB-1] E55 = 10'b0101010101;
  localparam bit [0:NB-1] EA3 = 10'b0110001011;
`endif
  logic clkin = 0, rst = 1, baud_in = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, txd, busy;
  uart_tx_ser #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clkin(clkin), .rst(rst), .baud_in(baud_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .busy(busy)
  );
  always #10 clkin = ~clkin;
  int nvec = 0, nerr = 0, cyc = 0;
  int unsigned bc = 0;
  bit b1, b2, b3, m_busy = 0, m_txd = 1;
  bit q[$];
  bit tr_txd[8192];
  bit tr_rdy[8192];

  task automatic chk(input string nm, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Frame model: a queue of line levels; each baud tick puts the next level on
  // the line, and the block is free again once the last stop level is out.
  task automatic model();
    bit tk;
    if (rst) begin
      m_txd = 1; m_busy = 0; q.delete();
      b1 = 0; b2 = 0; b3 = 0;
    end else begin
      tk = b2 & !b3;
      if (m_busy) begin
        if (tk) begin
          m_txd = q.pop_front();
          if (q.size() == 0) m_busy = 0;
        end
      end else if (tx_valid) begin
        m_busy = 1;
        q.delete();
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) q.push_back(tx_data[i]);
        if (PB == 1) q.push_back(^tx_data[DB-1:0]);
        for (int i = 0; i < SB; i++) q.push_back(1'b1);
      end
      b3 = b2; b2 = b1; b1 = baud_in;
    end
  endtask

  task automatic step();
    baud_in = bc[3];
    bc++;
    @(posedge clkin);
    model();
    @(negedge clkin);
    cyc++;
    if (cyc < 8192) begin
      tr_txd[cyc] = txd;
      tr_rdy[cyc] = tx_ready;
    end
    chk("txd", txd, m_txd);
    chk("tx_ready", tx_ready, !m_busy);
    chk("busy", busy, m_busy);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] d, output int acc);
    bit ok;
    int g;
    g = 0;
    tx_data = d;
    tx_valid = 1;
    do begin
      ok = !m_busy;
      step();
      g++;
    end while (!ok && g < 400);
    tx_valid = 0;
    acc = cyc;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL accept: byte %h not accepted within 400 cycles", d);
    end
  endtask

  task automatic find_fall(input int from, output int f);
    f = -1;
    for (int i = from + 1; i <= from + 48 && i < 8192; i++)
      if (f < 0 && tr_txd[i] == 1'b0) f = i;
    nvec++;
    if (f < 0) begin
      nerr++;
      $display("FAIL start_bit: got none expected one within 48 cycles of %0d", from);
      f = from;
    end
  endtask

  task automatic check_frame(input int f, input bit [0:NB-1] e, input string nm);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s_bit%0d", nm, i), tr_txd[f + 16*i + 8], e[i]);
    chk({nm, "_ready_low"}, tr_rdy[f + 16*(NB-1) - 1], 1'b0);
    chk({nm, "_ready_rise"}, tr_rdy[f + 16*(NB-1)], 1'b1);
  endtask

  initial begin
    int a, a2, f, n, g, st;
    bit all1;
    rst = 1;
    run(3);
    chk("rst_txd", txd, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst = 0;
    st = cyc;
    run(200);
    all1 = 1;
    for (int i = st + 1; i <= cyc; i++) all1 &= tr_txd[i];
    chk("idle_txd", all1, 1'b1);

    send(8'h55, a);
    run(NB*16 + 40);
    find_fall(a, f);
    check_frame(f, E55, "x55");

    send(8'hA3, a);
    run(NB*16 + 40);
    find_fall(a, f);
    check_frame(f, EA3, "xA3");

    send(8'h0F, a);
    send(8'hF0, a2);
    run(NB*16 + 40);
    find_fall(a, f);
    chki("b2b_accept_cycle", a2, f + 16*(NB-1) + 1);
    chk("b2b_stop", tr_txd[f + 16*NB - 1], 1'b1);
    chk("b2b_start", tr_txd[f + 16*NB], 1'b0);

    send(8'h00, a);
    run(40);
    find_fall(a, f);
    g = 0;
    while (cyc < f + 88 && g < 200) begin step(); g++; end
    chk("pre_rst_bit4", txd, 1'b0);
    rst = 1;
    #1;
    chk("async_txd", txd, 1'b1);
    chk("async_ready", tx_ready, 1'b1);
    chk("async_busy", busy, 1'b0);
    run(2);
    rst = 0;
    st = cyc;
    run(120);
    all1 = 1;
    for (int i = st + 1; i <= cyc; i++) all1 &= tr_txd[i];
    chk("no_residual", all1, 1'b1);

    g = 0;
    while (!(b2 && !b3) && g < 40) begin step(); g++; end
    chki("coinc_tick_found", g < 40, 1);
    tx_data = 8'($urandom);
    tx_valid = 1;
    step();
    tx_valid = 0;
    n = cyc;
    run(40);
    chk("coinc_hold", tr_txd[n + 15], 1'b1);
    chk("coinc_start", tr_txd[n + 16], 1'b0);

    repeat (2500) begin
      rst = ($urandom_range(0, 499) == 0);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      step();
    end
    rst = 0;
    tx_valid = 0;
    run(NB*16 + 40);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
- UART transmit serializer sitting directly downstream of the 115200 Hz baud divider.
- Runs entirely on the 50 MHz system clock and treats the divider's square-wave output as a data input, not a clock.
- Takes a byte through a valid/ready handshake and drives an 8-N-1 (optionally 8-E-1) frame on txd. Each bit lasts one baud period.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first (legal 5..8)
STOP_BITS, 1, number of stop bits (legal 1 or 2)

Ports:
clkin  input  1  system clock (50 MHz); all state updates on posedge
rst  input  1  asynchronous, active-high reset
baud_in  input  1  square wave from baud divider; rising edge marks a bit boundary
tx_data  input  DATA_BITS  byte to send; sampled only on accept
tx_valid  input  1  producer has tx_data ready
tx_ready  output  1  block can accept a byte this cycle
txd  output  1  serial line, idle high
busy  output  1  frame in progress (any state except IDLE)

Behaviour:
- Interface (decided): one clock, clkin; reset rst is asynchronous and active-high.
- Reset (async, any time including mid-frame):
  - Outputs: txd=1, tx_ready=1, busy=0.
  - Internal: state=IDLE, shift register=0, bit counter=0, sync flops=0.
  - A frame in flight is abandoned; no partial stop bit is sent.
- Baud tick:
  - baud_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - baud_tick is a 1-cycle pulse, 2-3 clkin cycles after the baud_in rising edge.
  - Ticks are ignored in IDLE.
- Accept: tx_valid && tx_ready on a posedge.
  - Latches tx_data and goes IDLE->ALIGN.
  - tx_ready=0 and busy=1 from the next cycle.
  - tx_valid while tx_ready=0 is ignored; no queueing.
- ALIGN: txd=1. The first baud_tick strictly after the accept cycle -> START with txd=0. A tick coincident with the accept cycle does not count.
- START: next tick -> DATA, txd=bit0.
- DATA:
  - Each tick shifts right and drives the next bit, LSB first.
  - Bit counter counts 0..DATA_BITS-1.
  - On the tick after the last bit -> PARITY if enabled, else STOP with txd=1.
- PARITY (optional): txd=even parity of the latched byte (XOR reduction) for one tick period, then STOP with txd=1.
- STOP:
  - txd=1 held for STOP_BITS tick periods.
  - On the final tick -> IDLE, with tx_ready=1 and busy=0 in the same cycle.
- Back-to-back: a new accept is possible in the first IDLE cycle; its start bit begins at the next tick, so there is no extra idle bit.
- Frame length: 1+DATA_BITS+STOP_BITS tick periods (+1 with parity). Every txd transition is registered on the baud_tick cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state present. An even-parity bit is inserted between the last data bit and the stop bit(s). Frame = 11 ticks for 8-bit, 1 stop.
- Undefined: no PARITY state or parity logic. DATA goes straight to STOP. Frame = 10 ticks.

Test Plan:
- Bench clocking for all scenarios: baud_in toggles every 8 clkin cycles (16-cycle bit period). Assert rst, release -> txd=1, tx_ready=1, busy=0; txd stays 1 with no valid for 200 cycles.
- Send 0x55, no parity -> txd after first tick is 0,1,0,1,0,1,0,1,0,1. Each level is held 16 cycles. tx_ready returns 1 after 10 ticks.
- Send 0xA3 with UART_TX_PARITY_EN -> txd is 0,1,1,0,0,0,1,0,1, then parity 0, then stop 1 (11 bit periods).
- Accept 0x0F, then hold tx_valid=1 with 0xF0 -> 0xF0 is accepted the cycle tx_ready rises. Its start bit begins exactly one bit period after 0x0F's stop bit starts, with no gap.
- Assert rst during data bit 4 of 0x00 -> txd=1 asynchronously, before the next clkin edge. After release, tx_ready=1 and no residual bits appear.
- Pulse tx_valid in the same cycle as a baud_tick -> txd stays 1 for that tick. The start bit starts on the following tick (16 cycles later).
